// File: rtl/bit_scan_unit.sv
// Bit-scan unit: finds the lowest/highest set or clear bit of a latched operand,
// examining one bit per cycle, and holds the result until downstream accepts it.
module bit_scan_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        type_i,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [5:0]        result_o,
  output logic              found_o
);

  localparam int unsigned PTR_W = $clog2(DATA_W);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DATA_W - 1);
  localparam logic [5:0] NO_MATCH = 6'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        type_q, type_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [5:0]        result_q, result_d;
  logic              found_q, found_d;

  logic hit;
  logic at_end;

  // type[0]=0 looks for a 1, type[1]=1 scans downward from the MSB
  assign hit    = (data_q[ptr_q] == ~type_q[0]);
  assign at_end = type_q[1] ? (ptr_q == '0) : (ptr_q == PTR_LAST);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    type_d   = type_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    found_d  = found_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_SCAN;
            data_d  = data_i;
            type_d  = type_i;
            ptr_d   = type_i[1] ? PTR_LAST : '0;
          end
        end
        S_SCAN: begin
          if (hit) begin
            result_d = 6'(ptr_q);
            found_d  = 1'b1;
            state_d  = S_DONE;
          end else if (at_end) begin
            result_d = NO_MATCH;
            found_d  = 1'b0;
            state_d  = S_DONE;
          end else begin
            ptr_d = type_q[1] ? ptr_q - 1'b1 : ptr_q + 1'b1;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      type_q   <= '0;
      ptr_q    <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      type_q   <= type_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      found_q  <= found_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;
  assign found_o  = found_q;

endmodule

// File: tb/tb_bit_scan_unit.sv
// Self-checking bench for bit_scan_unit: directed corner cases followed by
// randomized scans compared against a direct search model.
module tb_bit_scan_unit;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] data_i;
  logic [1:0]  type_i;
  logic        flush_i;
  logic        ready_i;
  logic        busy_o;
  logic        valid_o;
  logic [5:0]  result_o;
  logic        found_o;

  int errors = 0;
  int checks = 0;
  int last_res = 0;
  int last_fnd = 0;

  bit_scan_unit #(.DATA_W(32)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .data_i  (data_i),
    .type_i  (type_i),
    .flush_i (flush_i),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .result_o(result_o),
    .found_o (found_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Searches the operand in scan order; latency is the 1-based step of the match.
  task automatic model(input logic [31:0] d, input logic [1:0] t,
                       output int res, output int fnd, output int lat);
    res = 32;
    fnd = 0;
    lat = 32;
    for (int k = 0; k < 32; k++) begin
      int idx;
      idx = t[1] ? 31 - k : k;
      if (d[idx] == !t[0]) begin
        res = idx;
        fnd = 1;
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic scan_start(input logic [31:0] d, input logic [1:0] t);
    data_i  = d;
    type_i  = t;
    start_i = 1'b1;
    ready_i = 1'b0;
    tick();
    start_i = 1'b0;
    data_i  = $urandom;
    type_i  = 2'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!valid_o && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic full_scan(input string tag, input logic [31:0] d, input logic [1:0] t);
    int res, fnd, lat, got_lat;
    model(d, t, res, fnd, lat);
    scan_start(d, t);
    check({tag, ".busy"}, int'(busy_o), 1);
    wait_done(got_lat);
    check({tag, ".lat"}, got_lat, lat);
    check({tag, ".result"}, int'(result_o), res);
    check({tag, ".found"}, int'(found_o), fnd);
    last_res = res;
    last_fnd = fnd;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check({tag, ".idle_valid"}, int'(valid_o), 0);
    check({tag, ".idle_busy"}, int'(busy_o), 0);
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic [31:0] hold_d;
    int hres, hfnd, hlat;

    rst_ni  = 1'b1;
    start_i = 1'b0;
    data_i  = '0;
    type_i  = '0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("rst.busy", int'(busy_o), 0);
    check("rst.valid", int'(valid_o), 0);
    check("rst.result", int'(result_o), 0);
    check("rst.found", int'(found_o), 0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    full_scan("bit4_low1", 32'h0000_0010, 2'b00);
    full_scan("zero_high1", 32'h0000_0000, 2'b10);
    full_scan("zero_high0", 32'h0000_0000, 2'b11);
    full_scan("ones_low0", 32'hFFFF_FFFF, 2'b01);
    full_scan("7fff_high0", 32'h7FFF_FFFF, 2'b11);
    full_scan("7fff_high1", 32'h7FFF_FFFF, 2'b10);
    full_scan("msb_low1", 32'h8000_0000, 2'b00);
    full_scan("lsb_high1", 32'h0000_0001, 2'b10);

    // Result must hold in DONE while start pulses are ignored
    hold_d = 32'h0001_2000;
    model(hold_d, 2'b00, hres, hfnd, hlat);
    scan_start(hold_d, 2'b00);
    wait_done(lat);
    check("hold.lat", lat, hlat);
    for (int i = 0; i < 5; i++) begin
      start_i = 1'b1;
      data_i  = $urandom;
      type_i  = 2'($urandom);
      tick();
      check("hold.valid", int'(valid_o), 1);
      check("hold.result", int'(result_o), hres);
      check("hold.found", int'(found_o), hfnd);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    start_i = 1'b0;
    check("hold.release_busy", int'(busy_o), 0);
    check("hold.release_valid", int'(valid_o), 0);
    last_res = hres;
    last_fnd = hfnd;
    full_scan("after_hold", 32'h0400_0000, 2'b10);

    // Flush three steps into a long scan
    scan_start(32'h0000_0000, 2'b10);
    tick();
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_scan.busy", int'(busy_o), 0);
    check("flush_scan.valid", int'(valid_o), 0);
    check("flush_scan.result", int'(result_o), last_res);
    check("flush_scan.found", int'(found_o), last_fnd);
    for (int i = 0; i < 35; i++) begin
      tick();
      check("flush_scan.no_valid", int'(valid_o), 0);
    end

    // Flush while the result is waiting
    scan_start(32'h0000_0010, 2'b00);
    wait_done(lat);
    check("flush_done.lat", lat, 5);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_done.valid", int'(valid_o), 0);
    check("flush_done.busy", int'(busy_o), 0);
    check("flush_done.result", int'(result_o), 4);
    check("flush_done.found", int'(found_o), 1);

    start_i = 1'b1;
    flush_i = 1'b1;
    data_i  = 32'h1;
    type_i  = 2'b00;
    tick();
    start_i = 1'b0;
    flush_i = 1'b0;
    check("flush_start.busy", int'(busy_o), 0);
    tick();
    check("flush_start.busy2", int'(busy_o), 0);

    // Asynchronous reset mid-scan, observed before any further clock edge
    scan_start(32'h0000_0000, 2'b10);
    tick();
    tick();
    #2 rst_ni = 1'b0;
    #1;
    check("arst.busy", int'(busy_o), 0);
    check("arst.valid", int'(valid_o), 0);
    check("arst.result", int'(result_o), 0);
    check("arst.found", int'(found_o), 0);
    tick();
    rst_ni = 1'b1;
    full_scan("post_rst", 32'h8000_0000, 2'b10);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: rd = $urandom;
        1: rd = $urandom & $urandom & $urandom & $urandom;
        2: rd = $urandom | $urandom | $urandom | $urandom;
        3: rd = 32'h1 << $urandom_range(0, 31);
        4: rd = ~(32'h1 << $urandom_range(0, 31));
        default: rd = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
      endcase
      full_scan($sformatf("rnd%0d", n), rd, 2'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
